// File: rtl/camera_config_sequencer.sv
// Walks a {reg_addr, reg_value} init table from a registered ROM and issues
// each entry as an SCCB write, with support for timed delays and an end marker.
module camera_config_sequencer #(
  parameter int ROM_ADDR_W     = 8,
  parameter int POWERUP_CYCLES = 25000000,
  parameter int DELAY_CYCLES   = 250000,
  parameter bit AUTO_START     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [15:0]           rom_data,
  input  logic                  sccb_ready,
  output logic                  sccb_start,
  output logic [7:0]            sccb_addr,
  output logic [7:0]            sccb_data,
  output logic                  cfg_busy,
  output logic                  cfg_done,
  output logic [ROM_ADDR_W:0]   write_count
);

  localparam int TMAX = (POWERUP_CYCLES > DELAY_CYCLES) ? POWERUP_CYCLES : DELAY_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0]         PU_LAST  = TW'(POWERUP_CYCLES - 1);
  localparam logic [TW-1:0]         DLY_LAST = TW'(DELAY_CYCLES - 1);
  localparam logic [TW-1:0]         T_ONE    = 1;
  localparam logic [ROM_ADDR_W-1:0] A_ONE    = 1;
  localparam logic [ROM_ADDR_W:0]   WC_ONE   = 1;

  typedef enum logic [3:0] {
    IDLE, POWERUP, FETCH, DECODE, ISSUE, WAIT_BUSY, WAIT_DONE, DELAY, DONE
  } state_t;

  state_t        state, next_state;
  logic [TW-1:0] timer;
  logic          at_max, is_end, is_dly;

  assign at_max = &rom_addr;
  assign is_end = (rom_data == 16'hFFFF);
  assign is_dly = (rom_data == 16'hFFF0);

  always_ff @(posedge clk) begin
    if (rst) state <= AUTO_START ? POWERUP : IDLE;
    else     state <= next_state;
  end

  // The last table slot finishes the run instead of wrapping back to entry 0.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (cfg_start) next_state = FETCH;
      POWERUP:   if (timer == PU_LAST) next_state = FETCH;
      FETCH:     next_state = DECODE;
      DECODE:    next_state = is_end ? DONE : (is_dly ? DELAY : ISSUE);
      ISSUE:     if (sccb_ready) next_state = WAIT_BUSY;
      WAIT_BUSY: if (!sccb_ready) next_state = WAIT_DONE;
      WAIT_DONE: if (sccb_ready) next_state = at_max ? DONE : FETCH;
      DELAY:     if (timer == '0) next_state = at_max ? DONE : FETCH;
      DONE:      if (cfg_start) next_state = FETCH;
      default:   next_state = IDLE;
    endcase
  end

  // Request is gated by the engine's ready so it can never land on a busy engine.
  always_comb begin
    sccb_start = (state == ISSUE) && sccb_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr    <= '0;
      timer       <= '0;
      sccb_addr   <= '0;
      sccb_data   <= '0;
      cfg_busy    <= 1'b0;
      cfg_done    <= 1'b0;
      write_count <= '0;
    end else begin
      cfg_busy <= !(next_state inside {IDLE, DONE});
      cfg_done <= (next_state == DONE);
      case (state)
        IDLE, DONE: if (cfg_start) begin
          rom_addr    <= '0;
          write_count <= '0;
        end
        POWERUP: timer <= (timer == PU_LAST) ? '0 : timer + T_ONE;
        DECODE: begin
          if (is_dly) timer <= DLY_LAST;
          else if (!is_end) begin
            sccb_addr <= rom_data[15:8];
            sccb_data <= rom_data[7:0];
          end
        end
        WAIT_DONE: if (sccb_ready) begin
          write_count <= write_count + WC_ONE;
          if (!at_max) rom_addr <= rom_addr + A_ONE;
        end
        DELAY: begin
          if (timer == '0) begin
            if (!at_max) rom_addr <= rom_addr + A_ONE;
          end else begin
            timer <= timer - T_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_camera_config_sequencer.sv
// Bench for camera_config_sequencer: a table-walking scoreboard predicts the
// write stream, plus directed runs for delay, stall, re-trigger, wrap and reset.
module tb_camera_config_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Main instance: 8-bit table, auto start
  logic        rst, cs1, hold_low;
  logic [7:0]  ra1;
  logic [15:0] rd1;
  logic        rdy1, st1, busy1, done1;
  logic [7:0]  sa1, sd1;
  logic [8:0]  wc1;
  logic [15:0] rom1 [256];
  int          bc1 = 0;

  // Small instance: 4-entry table, manual start
  logic        cs2;
  logic [1:0]  ra2;
  logic [15:0] rd2;
  logic        rdy2, st2, busy2, done2;
  logic [7:0]  sa2, sd2;
  logic [2:0]  wc2;
  logic [15:0] rom2 [4];
  int          bc2 = 0;

  camera_config_sequencer #(.ROM_ADDR_W(8), .POWERUP_CYCLES(10), .DELAY_CYCLES(100),
                            .AUTO_START(1'b1)) dut (
    .clk(clk), .rst(rst), .cfg_start(cs1), .rom_addr(ra1), .rom_data(rd1),
    .sccb_ready(rdy1), .sccb_start(st1), .sccb_addr(sa1), .sccb_data(sd1),
    .cfg_busy(busy1), .cfg_done(done1), .write_count(wc1));

  camera_config_sequencer #(.ROM_ADDR_W(2), .POWERUP_CYCLES(10), .DELAY_CYCLES(5),
                            .AUTO_START(1'b0)) dut2 (
    .clk(clk), .rst(rst), .cfg_start(cs2), .rom_addr(ra2), .rom_data(rd2),
    .sccb_ready(rdy2), .sccb_start(st2), .sccb_addr(sa2), .sccb_data(sd2),
    .cfg_busy(busy2), .cfg_done(done2), .write_count(wc2));

  // Registered ROMs and SCCB engines (engines are not reset by rst)
  always @(posedge clk) begin
    rd1 <= rom1[ra1];
    rd2 <= rom2[ra2];
    if (st1) bc1 <= 50; else if (bc1 > 0) bc1 <= bc1 - 1;
    if (st2) bc2 <= 3;  else if (bc2 > 0) bc2 <= bc2 - 1;
  end
  assign rdy1 = (bc1 == 0) && !hold_low;
  assign rdy2 = (bc2 == 0);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard: the writes a run must produce, straight from the table contents
  logic [15:0] q1[$], q2[$], log1[$];
  int exp_wc1 = 0, exp_wc2 = 0;

  task automatic rebuild1();
    q1.delete();
    for (int i = 0; i < 256; i++) begin
      if (rom1[i] == 16'hFFFF) break;
      if (rom1[i] != 16'hFFF0) q1.push_back(rom1[i]);
    end
    exp_wc1 = q1.size();
  endtask

  task automatic rebuild2();
    q2.delete();
    for (int i = 0; i < 4; i++) begin
      if (rom2[i] == 16'hFFFF) break;
      if (rom2[i] != 16'hFFF0) q2.push_back(rom2[i]);
    end
    exp_wc2 = q2.size();
  endtask

  task automatic set_rom1(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    for (int i = 0; i < 256; i++) rom1[i] = 16'hFFFF;
    rom1[0] = a; rom1[1] = b; rom1[2] = c;
  endtask

  // Compare process: every negedge outside reset
  int   n1 = 0, n2 = 0, first1 = 0;
  logic prev1 = 1'b0, prev2 = 1'b0, seen_nz2 = 1'b0, wrap2 = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev1 = 1'b0; prev2 = 1'b0;
    end else begin
      chk("busy_done_excl1", {31'd0, busy1 & done1}, 0);
      if (done1 && !cs1) chk("wc_at_done1", wc1, exp_wc1);
      if (st1) begin
        n1++;
        if (first1 < 0) first1 = cyc;
        chk("start_while_busy1", rdy1, 1);
        chk("start_back2back1", prev1, 0);
        log1.push_back({sa1, sd1});
        if (q1.size() == 0) chk("extra_write1", n1, 0);
        else chk("write_payload1", {sa1, sd1}, q1.pop_front());
      end
      prev1 = st1;
      if (busy2) begin
        if (ra2 != 2'd0) seen_nz2 = 1'b1;
        else if (seen_nz2) wrap2 = 1'b1;
      end
      if (done2 && !cs2) chk("wc_at_done2", wc2, exp_wc2);
      if (st2) begin
        n2++;
        chk("start_while_busy2", rdy2, 1);
        chk("start_back2back2", prev2, 0);
        if (q2.size() == 0) chk("extra_write2", n2, 0);
        else chk("write_payload2", {sa2, sd2}, q2.pop_front());
      end
      prev2 = st2;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done1(input int lim);
    for (int i = 0; i < lim && !done1; i++) tick();
    chk("done1_timeout", done1, 1);
  endtask

  task automatic chk_zero1(input string tag);
    chk({tag, "_rom_addr"}, ra1, 0);
    chk({tag, "_sccb_start"}, st1, 0);
    chk({tag, "_sccb_addr"}, sa1, 0);
    chk({tag, "_sccb_data"}, sd1, 0);
    chk({tag, "_busy"}, busy1, 0);
    chk({tag, "_done"}, done1, 0);
    chk({tag, "_write_count"}, wc1, 0);
  endtask

  int t0, nb;

  initial begin
    rst = 1'b1; cs1 = 1'b0; cs2 = 1'b0; hold_low = 1'b1;
    set_rom1(16'h1280, 16'h1204, 16'hFFFF);
    rebuild1();
    repeat (3) tick();
    chk_zero1("reset");

    // Run A: auto start, engine stalled ~30 cycles, cfg_start pulses ignored
    rst = 1'b0;
    tick();
    chk("powerup_busy", busy1, 1);
    chk("idle2_busy", busy2, 0);
    repeat (5) tick();
    cs1 = 1'b1; tick(); cs1 = 1'b0;
    repeat (10) tick();
    cs1 = 1'b1; tick(); cs1 = 1'b0;
    repeat (10) tick();
    chk("stall_no_start", n1, 0);
    hold_low = 1'b0;
    wait_done1(1000);
    chk("A_write_count", wc1, 2);
    chk("A_busy", busy1, 0);
    chk("A_starts", n1, 2);
    chk("A_w0", log1[0], 16'h1280);
    chk("A_w1", log1[1], 16'h1204);
    chk("A_rom_addr", ra1, 2);
    chk("A_queue_left", q1.size(), 0);
    chk("idle2_still_busy", busy2, 0);
    chk("idle2_done", done2, 0);

    // Run B: delay entry, re-trigger from DONE skips power-up
    set_rom1(16'hFFF0, 16'h1101, 16'hFFFF);
    rebuild1();
    first1 = -1;
    cs1 = 1'b1; tick(); cs1 = 1'b0;
    t0 = cyc;
    chk("B_done_cleared", done1, 0);
    chk("B_busy", busy1, 1);
    chk("B_rom_addr", ra1, 0);
    chk("B_wc_cleared", wc1, 0);
    wait_done1(1000);
    chk("B_start_latency", first1 - t0, 104);
    chk("B_write_count", wc1, 1);
    chk("B_w", log1[2], 16'h1101);
    chk("B_queue_left", q1.size(), 0);

    // Run C: reset while the SCCB write is outstanding; rst beats cfg_start
    set_rom1(16'h1234, 16'h5678, 16'hFFFF);
    rebuild1();
    nb = n1;
    cs1 = 1'b1; tick(); cs1 = 1'b0;
    for (int i = 0; i < 200 && n1 == nb; i++) tick();
    chk("C_first_write_seen", n1, nb + 1);
    for (int i = 0; i < 10 && rdy1; i++) tick();
    repeat (3) tick();
    rst = 1'b1; cs1 = 1'b1;
    tick();
    chk_zero1("midreset");
    rst = 1'b0; cs1 = 1'b0;
    rebuild1();
    tick();
    chk("C_powerup_busy", busy1, 1);
    chk("C_no_early_fetch", ra1, 0);
    wait_done1(2000);
    chk("C_write_count", wc1, 2);
    chk("C_starts", n1, 6);
    chk("C_w0", log1[4], 16'h1234);
    chk("C_w1", log1[5], 16'h5678);
    chk("C_queue_left", q1.size(), 0);

    // Run D: full 4-entry table with no end marker
    rom2[0] = 16'h0111; rom2[1] = 16'h0222; rom2[2] = 16'h0333; rom2[3] = 16'h0444;
    rebuild2();
    seen_nz2 = 1'b0; wrap2 = 1'b0;
    cs2 = 1'b1; tick(); cs2 = 1'b0;
    for (int i = 0; i < 500 && !done2; i++) tick();
    chk("D_done", done2, 1);
    chk("D_write_count", wc2, 4);
    chk("D_rom_addr", ra2, 3);
    chk("D_no_wrap", wrap2, 0);
    chk("D_starts", n2, 4);
    chk("D_busy", busy2, 0);
    chk("D_queue_left", q2.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
